bit_arith_cell: RTL and testbench
=================================

Name: bit_arith_cell

Overview:
- Single-bit arithmetic primitive block. It evaluates a half adder, a full adder and a full subtractor on a shared (a, b, cin) operand triple.
- All three results are registered, so downstream ripple or ALU logic sees aligned, clocked outputs.
- The combinational cores (half_adder, full_adder, full_sub) are instantiated inside this block. Their boolean contracts are defined here.

Parameters:
- REG_OUT, 1, 1 = results registered (1-cycle latency); 0 = results and out_valid are combinational pass-through, and clk/rst are unused except for out_valid gating described below.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- a  input  1  operand A (minuend for subtractor).
- b  input  1  operand B (subtrahend for subtractor).
- cin  input  1  carry-in for the adder, borrow-in for the subtractor; ignored by the half adder.
- in_valid  input  1  operands valid this cycle.
- ha_s  output  1  half-adder sum.
- ha_cout  output  1  half-adder carry.
- fa_s  output  1  full-adder sum.
- fa_cout  output  1  full-adder carry.
- fs_d  output  1  full-subtractor difference.
- fs_bout  output  1  full-subtractor borrow-out.
- out_valid  output  1  outputs correspond to a valid operand set.

Behaviour:
- half_adder core: {ha_cout, ha_s} = a + b (2-bit unsigned). ha_s = a^b, ha_cout = a&b.
- full_adder core: {fa_cout, fa_s} = a + b + cin (2-bit unsigned). fa_s = a^b^cin, fa_cout = ab | acin | bcin.
- full_sub core: {fs_bout, fs_d} = (a - b - cin) mod 4 (2-bit two's complement). fs_d = a^b^cin, fs_bout = (~a&b) | (~a&cin) | (b&cin).
- Cores are purely combinational, with no state and no X propagation beyond the inputs.
- REG_OUT=1:
  - On each rising clk with rst=0, all six result registers capture the core outputs and out_valid captures in_valid.
  - Latency is exactly 1 cycle.
  - Result registers update every cycle regardless of in_valid; out_valid qualifies them.
- Reset: rst=1 at a rising edge forces all six result outputs and out_valid to 0 on that edge. Reset takes priority over capture.
- Reset asserted mid-stream: the pending result is discarded. The first valid output after deassertion appears one cycle after the first in_valid=1 sampled with rst=0.
- REG_OUT=0:
  - All six result outputs follow the inputs combinationally.
  - out_valid = in_valid & ~rst.
- Outputs are never X after the first reset edge.

Test Plan:
- Reset: hold rst=1 for 2 cycles with a=b=cin=1 and in_valid=1 -> all outputs 0 and out_valid=0. Deassert rst -> next edge gives ha 10, fa 11, fs 11 (d=1, bout=1), out_valid=1.
- Exhaustive sweep of all 8 (a,b,cin) combinations, one per cycle, in_valid=1. Each result must match the previous cycle's inputs:
  - 000 -> ha 00, fa 00, fs 00
  - 001 -> ha 00, fa 01, fs 11
  - 010 -> ha 01, fa 01, fs 11
  - 011 -> ha 01, fa 10, fs 10
  - 100 -> ha 01, fa 01, fs 01
  - 101 -> ha 01, fa 10, fs 00
  - 110 -> ha 10, fa 10, fs 00
  - 111 -> ha 10, fa 11, fs 11
  - Each pair is {carry/borrow, sum/diff}.
- Random: 50 cycles of random a, b, cin, in_valid. Each cycle check {fa_cout,fa_s}==a+b+cin, {ha_cout,ha_s}==a+b and {fs_bout,fs_d}==(a-b-cin)&3 against 1-cycle-delayed inputs. out_valid must equal in_valid delayed by 1.
- Mid-stream reset: drive a=1, b=0, cin=0, assert rst for one cycle -> outputs 0 that cycle. With rst low the next edge gives fa 01, fs 01, out_valid=1.
- REG_OUT=0 build: apply a=0, b=1, cin=1 -> same cycle fa 10, fs 10, ha 01. With rst=1, out_valid=0.

Source files
------------

// File: rtl/bit_arith_cell.sv
// bit_arith_cell: single-bit half adder, full adder and full subtractor
// sharing one (a, b, cin) operand triple, with optional output registers.

// half_adder: {cout, s} = a + b
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic cout
);
   assign s    = a ^ b;
   assign cout = a & b;
endmodule

// full_adder: {cout, s} = a + b + cin
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// full_sub: {bout, d} = (a - b - bin) mod 4
module full_sub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// Top: evaluates all three cores every cycle; REG_OUT selects a
// 1-cycle registered result or a combinational pass-through.
module bit_arith_cell #(
   parameter bit REG_OUT = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic in_valid,
   output logic ha_s,
   output logic ha_cout,
   output logic fa_s,
   output logic fa_cout,
   output logic fs_d,
   output logic fs_bout,
   output logic out_valid
);

   typedef struct packed {
      logic ha_cout;
      logic ha_s;
      logic fa_cout;
      logic fa_s;
      logic fs_bout;
      logic fs_d;
   } res_t;

   logic ha_s_c, ha_cout_c, fa_s_c, fa_cout_c, fs_d_c, fs_bout_c;
   res_t res_c;
   res_t res_o;
   logic vld_o;

   half_adder u_ha (
      .a    (a),
      .b    (b),
      .s    (ha_s_c),
      .cout (ha_cout_c)
   );

   full_adder u_fa (
      .a    (a),
      .b    (b),
      .cin  (cin),
      .s    (fa_s_c),
      .cout (fa_cout_c)
   );

   full_sub u_fs (
      .a    (a),
      .b    (b),
      .bin  (cin),
      .d    (fs_d_c),
      .bout (fs_bout_c)
   );

   assign res_c = '{ha_cout: ha_cout_c, ha_s: ha_s_c,
                    fa_cout: fa_cout_c, fa_s: fa_s_c,
                    fs_bout: fs_bout_c, fs_d: fs_d_c};

   generate
      if (REG_OUT) begin : g_reg
         res_t res_q;
         logic vld_q;

         // Results capture every cycle; valid qualifies them. Reset wins.
         always_ff @(posedge clk) begin
            if (rst) begin
               res_q <= '0;
               vld_q <= 1'b0;
            end else begin
               res_q <= res_c;
               vld_q <= in_valid;
            end
         end

         assign res_o = res_q;
         assign vld_o = vld_q;
      end else begin : g_comb
         // Pass-through: only valid is gated by reset.
         assign res_o = res_c;
         assign vld_o = in_valid & ~rst;
      end
   endgenerate

   assign ha_s      = res_o.ha_s;
   assign ha_cout   = res_o.ha_cout;
   assign fa_s      = res_o.fa_s;
   assign fa_cout   = res_o.fa_cout;
   assign fs_d      = res_o.fs_d;
   assign fs_bout   = res_o.fs_bout;
   assign out_valid = vld_o;

endmodule

// File: tb/tb_bit_arith_cell.sv
// Self-checking bench for bit_arith_cell: registered build via a scoreboard
// queue, plus a combinational build checked in the same cycle.
module tb_bit_arith_cell;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // registered instance
   logic rst, a, b, cin, in_valid;
   logic ha_s, ha_cout, fa_s, fa_cout, fs_d, fs_bout, out_valid;

   // combinational instance
   logic c_rst, c_a, c_b, c_cin, c_in_valid;
   logic c_ha_s, c_ha_cout, c_fa_s, c_fa_cout, c_fs_d, c_fs_bout, c_out_valid;

   int tests = 0;
   int fails = 0;

   logic [6:0] exp_q[$];

   bit_arith_cell #(.REG_OUT(1'b1)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
      .ha_s(ha_s), .ha_cout(ha_cout), .fa_s(fa_s), .fa_cout(fa_cout),
      .fs_d(fs_d), .fs_bout(fs_bout), .out_valid(out_valid)
   );

   bit_arith_cell #(.REG_OUT(1'b0)) dut_c (
      .clk(clk), .rst(c_rst), .a(c_a), .b(c_b), .cin(c_cin), .in_valid(c_in_valid),
      .ha_s(c_ha_s), .ha_cout(c_ha_cout), .fa_s(c_fa_s), .fa_cout(c_fa_cout),
      .fs_d(c_fs_d), .fs_bout(c_fs_bout), .out_valid(c_out_valid)
   );

   // Arithmetic reference: {valid, ha[1:0], fa[1:0], fs[1:0]}
   function automatic logic [6:0] model(input logic ia, input logic ib,
                                        input logic ic, input logic iv);
      int ha, fa, fs;
      ha = int'(ia) + int'(ib);
      fa = int'(ia) + int'(ib) + int'(ic);
      fs = (int'(ia) - int'(ib) - int'(ic)) & 3;
      return {iv, 2'(ha), 2'(fa), 2'(fs)};
   endfunction

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   // Drive one operand set, push its expected result, then compare after the edge.
   task automatic step(input string tag, input logic ia, input logic ib, input logic ic,
                       input logic iv, input logic ir, input logic [6:0] expv);
      logic [6:0] e;
      a = ia; b = ib; cin = ic; in_valid = iv; rst = ir;
      exp_q.push_back(expv);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         check(tag, {out_valid, ha_cout, ha_s, fa_cout, fa_s, fs_bout, fs_d}, e);
      end
   endtask

   logic [5:0] tbl [8];

   initial begin
      tbl = '{6'b000000, 6'b000111, 6'b010111, 6'b011010,
              6'b010101, 6'b011000, 6'b101000, 6'b101111};
      c_rst = 1'b0; c_a = 1'b0; c_b = 1'b0; c_cin = 1'b0; c_in_valid = 1'b0;

      // reset held two cycles with all-ones operands
      step("reset0", 1, 1, 1, 1, 1, 7'b0);
      step("reset1", 1, 1, 1, 1, 1, 7'b0);
      step("post_reset", 1, 1, 1, 1, 0, 7'b1_10_11_11);

      // exhaustive sweep against the truth table
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         step($sformatf("sweep%0d", i), v[2], v[1], v[0], 1, 0, {1'b1, tbl[i]});
      end

      // random operands and valid
      for (int i = 0; i < 50; i++) begin
         logic ra, rb, rc, rv;
         ra = 1'($urandom_range(0, 1));
         rb = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         rv = 1'($urandom_range(0, 1));
         step($sformatf("rand%0d", i), ra, rb, rc, rv, 0, model(ra, rb, rc, rv));
      end

      // mid-stream reset discards the pending result
      step("mid_rst", 1, 0, 0, 1, 1, 7'b0);
      step("mid_rel", 1, 0, 0, 1, 0, 7'b1_01_01_01);
      step("idle", 0, 0, 0, 0, 0, 7'b0_00_00_00);

      // combinational build: same-cycle results
      c_a = 1'b0; c_b = 1'b1; c_cin = 1'b1; c_in_valid = 1'b1; c_rst = 1'b0;
      #1;
      check("comb_011", {c_out_valid, c_ha_cout, c_ha_s, c_fa_cout, c_fa_s, c_fs_bout, c_fs_d},
            7'b1_01_10_10);
      c_rst = 1'b1;
      #1;
      check("comb_rst", {c_out_valid, c_ha_cout, c_ha_s, c_fa_cout, c_fa_s, c_fs_bout, c_fs_d},
            7'b0_01_10_10);
      c_rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         c_a = v[2]; c_b = v[1]; c_cin = v[0]; c_in_valid = v[0] ^ v[2];
         #1;
         check($sformatf("comb_sweep%0d", i),
               {c_out_valid, c_ha_cout, c_ha_s, c_fa_cout, c_fa_s, c_fs_bout, c_fs_d},
               model(v[2], v[1], v[0], v[0] ^ v[2]));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
